rabbit_next_state: RTL and testbench

- Rabbit next-state stage, directly downstream of the counter-update stage.
- Consumes the updated 8x32-bit counters C0..C7 and the current 8x32-bit state X0..X7, and produces the next state X'0..X'7.
- Iterative, area-reduced: one shared 32-bit squarer computes one g-function per cycle, then a single combine cycle produces all eight X' words.
- start/busy/done handshake to the round controller.

---
 rtl/rabbit_pkg.sv | 30 +++
 rtl/rabbit_g_func.sv | 19 +
 rtl/rabbit_next_state.sv | 132 +++++++++++++
 tb/tb_rabbit_next_state.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rabbit_pkg.sv
// Shared Rabbit cipher constants, rotate amounts and next-state FSM encoding.
// Counter constants live here so the counter-update stage and this stage agree.
package rabbit_pkg;

  localparam int W     = 32;
  localparam int LANES = 8;

  localparam logic [W-1:0] A0 = 32'h4D34D34D;
  localparam logic [W-1:0] A1 = 32'hD34D34D3;
  localparam logic [W-1:0] A2 = 32'h34D34D34;
  localparam logic [W-1:0] A3 = 32'h4D34D34D;
  localparam logic [W-1:0] A4 = 32'hD34D34D3;
  localparam logic [W-1:0] A5 = 32'h34D34D34;
  localparam logic [W-1:0] A6 = 32'h4D34D34D;
  localparam logic [W-1:0] A7 = 32'hD34D34D3;

  localparam int ROT8  = 8;
  localparam int ROT16 = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GCALC = 2'd1,
    COMB  = 2'd2
  } state_t;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    return (v << n) | (v >> (W - n));
  endfunction

endpackage

// File: rtl/rabbit_g_func.sv
// Rabbit g-function: square of (x + c) mod 2^32, low half XOR high half.
// Latency: purely combinational.
// Backpressure: none, the caller time-multiplexes one instance across lanes.
module rabbit_g_func
  import rabbit_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] c,
  output logic [W-1:0] g
);

  logic [W-1:0]   u;
  logic [2*W-1:0] sq;

  assign u  = x + c;
  assign sq = {{W{1'b0}}, u} * {{W{1'b0}}, u};
  assign g  = sq[W-1:0] ^ sq[2*W-1:W];

endmodule

// File: rtl/rabbit_next_state.sv
// Rabbit next-state stage: one shared g-function per cycle, then one combine cycle.
// Latency: start edge k, g0..g7 at k+1..k+8, state_out/done at k+9; 10-cycle throughput.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
module rabbit_next_state
  import rabbit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W*LANES-1:0] counter_in,
  input  logic [W*LANES-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic [W*LANES-1:0] state_out
);

  state_t       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         load_op, g_we, out_we;

  logic [W-1:0] x_q [LANES];
  logic [W-1:0] c_q [LANES];
  logic [W-1:0] g_q [LANES];

  logic [W-1:0]       x_cur, c_cur, g_cur;
  logic [W-1:0]       xn [LANES];
  logic [W*LANES-1:0] xn_flat;

  assign x_cur = x_q[idx_q];
  assign c_cur = c_q[idx_q];

  rabbit_g_func u_g_func (
    .x (x_cur),
    .c (c_cur),
    .g (g_cur)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_op = 1'b0;
    g_we    = 1'b0;
    out_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_op = 1'b1;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          state_d = GCALC;
        end
      end
      GCALC: begin
        g_we = 1'b1;
        if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          state_d = COMB;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      COMB: begin
        out_we  = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Even lanes mix two 16-bit rotations, odd lanes one 8-bit rotation plus a plain word.
  always_comb begin
    xn[0] = g_q[0] + rotl(g_q[7], ROT16) + rotl(g_q[6], ROT16);
    xn[1] = g_q[1] + rotl(g_q[0], ROT8)  + g_q[7];
    xn[2] = g_q[2] + rotl(g_q[1], ROT16) + rotl(g_q[0], ROT16);
    xn[3] = g_q[3] + rotl(g_q[2], ROT8)  + g_q[1];
    xn[4] = g_q[4] + rotl(g_q[3], ROT16) + rotl(g_q[2], ROT16);
    xn[5] = g_q[5] + rotl(g_q[4], ROT8)  + g_q[3];
    xn[6] = g_q[6] + rotl(g_q[5], ROT16) + rotl(g_q[4], ROT16);
    xn[7] = g_q[7] + rotl(g_q[6], ROT8)  + g_q[5];
    for (int j = 0; j < LANES; j++) begin
      xn_flat[W*j +: W] = xn[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      state_out <= '0;
      for (int j = 0; j < LANES; j++) begin
        x_q[j] <= '0;
        c_q[j] <= '0;
        g_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load_op) begin
        for (int j = 0; j < LANES; j++) begin
          x_q[j] <= state_in[W*j +: W];
          c_q[j] <= counter_in[W*j +: W];
        end
      end
      if (g_we) begin
        g_q[idx_q] <= g_cur;
      end
      if (out_we) begin
        state_out <= xn_flat;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);
  a_gcalc_busy:    assert property (@(posedge clk) disable iff (!rst_n) (state_q == GCALC) |-> busy_q);

endmodule

// File: tb/tb_rabbit_next_state.sv
// Self-checking bench for rabbit_next_state: directed vector table, handshake
// sequences and randomized operands against a formula-level reference model.
module tb_rabbit_next_state;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] counter_in;
  logic [255:0] state_in;
  logic         busy;
  logic         done;
  logic [255:0] state_out;

  int checks = 0;
  int fails  = 0;

  rabbit_next_state dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .counter_in (counter_in),
    .state_in   (state_in),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] c;
    logic [255:0] x;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Straight from the algorithm: square as a 64-bit integer, fold halves, mix lanes.
  function automatic logic [255:0] model(input logic [255:0] c, input logic [255:0] x);
    logic [31:0]  g [8];
    logic [31:0]  o [8];
    logic [31:0]  u;
    logic [63:0]  s;
    logic [255:0] r;
    for (int j = 0; j < 8; j++) begin
      u    = x[32*j +: 32] + c[32*j +: 32];
      s    = {32'h0, u} * {32'h0, u};
      g[j] = s[31:0] ^ s[63:32];
    end
    o[0] = g[0] + rl(g[7], 16) + rl(g[6], 16);
    o[1] = g[1] + rl(g[0], 8)  + g[7];
    o[2] = g[2] + rl(g[1], 16) + rl(g[0], 16);
    o[3] = g[3] + rl(g[2], 8)  + g[1];
    o[4] = g[4] + rl(g[3], 16) + rl(g[2], 16);
    o[5] = g[5] + rl(g[4], 8)  + g[3];
    o[6] = g[6] + rl(g[5], 16) + rl(g[4], 16);
    o[7] = g[7] + rl(g[6], 8)  + g[5];
    for (int j = 0; j < 8; j++) r[32*j +: 32] = o[j];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Presents operands with start for one edge, scrambles inputs afterwards,
  // and returns the number of edges after the start edge until done.
  task automatic run_op(input logic [255:0] c, input logic [255:0] x, input bit sync_negedge,
                        output logic [255:0] res, output int lat);
    if (sync_negedge) @(negedge clk);
    counter_in = c;
    state_in   = x;
    start      = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1'b1);
    start      = 1'b0;
    counter_in = rand256();
    state_in   = rand256();
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    res = state_out;
  endtask

  initial begin
    logic [255:0] res, c, x, exp;
    int           lat, dcnt;

    vecs[0] = '{"all_zero",   256'h0,         256'h0,         256'h0};
    vecs[1] = '{"c0_one",     256'h1,         256'h0,         {160'h0, 32'h00010000, 32'h00000100, 32'h00000001}};
    vecs[2] = '{"x0_hi_half", 256'h0,         256'h00010000,  {160'h0, 32'h00010000, 32'h00000100, 32'h00000001}};
    vecs[3] = '{"u_wraps",    256'hFFFFFFFF,  256'h1,         256'h0};
    vecs[4] = '{"x0_all_one", 256'h0,         256'hFFFFFFFF,  {160'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};

    rst_n      = 1'b0;
    start      = 1'b0;
    counter_in = '0;
    state_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_state_out", state_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].c, vecs[i].x, 1'b1, res, lat);
      chk({vecs[i].name, "_latency"}, lat, 9);
      chk({vecs[i].name, "_busy_at_done"}, busy, 1'b0);
      chk(vecs[i].name, res, vecs[i].exp);
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_pulse"}, done, 1'b0);
      chk({vecs[i].name, "_hold"}, state_out, vecs[i].exp);
    end

    // Back-to-back: new start issued in the done cycle.
    c = rand256();
    x = rand256();
    run_op(c, x, 1'b1, res, lat);
    chk("b2b_first", res, model(c, x));
    c = rand256();
    x = rand256();
    run_op(c, x, 1'b0, res, lat);
    chk("b2b_second_latency", lat, 9);
    chk("b2b_second", res, model(c, x));

    // start held high for 20 edges: two accepted starts, two dones.
    c = rand256();
    x = rand256();
    @(negedge clk);
    counter_in = c;
    state_in   = x;
    start      = 1'b1;
    dcnt       = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("held_start_result", state_out, model(c, x));
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("held_start_done_count", dcnt, 2);

    // Reset in the middle of GCALC aborts the computation.
    @(negedge clk);
    counter_in = rand256();
    state_in   = rand256();
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midop_reset_busy", busy, 1'b0);
    chk("midop_reset_done", done, 1'b0);
    chk("midop_reset_state_out", state_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("no_stale_done", dcnt, 0);
    c = rand256();
    x = rand256();
    run_op(c, x, 1'b1, res, lat);
    chk("post_reset_latency", lat, 9);
    chk("post_reset_result", res, model(c, x));

    for (int it = 0; it < 1000; it++) begin
      c = rand256();
      x = rand256();
      exp = model(c, x);
      run_op(c, x, 1'b1, res, lat);
      chk("rand_latency", lat, 9);
      chk("rand_result", res, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
